// File: rtl/stepdown_discharge_pkg.sv
// Shared types and default constants for the
// stepdown output discharge sequencer.
package stepdown_discharge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEGLITCH,
    ST_DISCHARGE,
    ST_DONE,
    ST_TIMEOUT
  } dis_state_t;

  localparam int DEF_DEG_CYC  = 16;
  localparam int DEF_PER_CYC  = 8;
  localparam int DEF_ON_CYC   = 6;
  localparam int DEF_DONE_CYC = 4;
  localparam int DEF_MAX_CYC  = 4096;
  localparam int DEF_CNT_W    = 12;

endpackage

// File: rtl/pebble_sync2.sv
// Two-flop synchroniser for asynchronous control
// inputs, with a selectable reset value.
module pebble_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/stepdown_discharge_ctrl.sv
// Discharge sequencer: deglitches the disable, chops the
// discharge switch and ends on vout_low or timeout.
module stepdown_discharge_ctrl
  import stepdown_discharge_pkg::*;
#(
  parameter int DEG_CYC  = DEF_DEG_CYC,
  parameter int PER_CYC  = DEF_PER_CYC,
  parameter int ON_CYC   = DEF_ON_CYC,
  parameter int DONE_CYC = DEF_DONE_CYC,
  parameter int MAX_CYC  = DEF_MAX_CYC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic vout_low,
  input  logic uvlo_n,
  input  logic fault_clr,
  output logic dis_arm,
  output logic dis_pulse,
  output logic busy,
  output logic done,
  output logic fault
);

  localparam logic [7:0] DEG_LAST = 8'(DEG_CYC);
  localparam logic [7:0] PER_LAST = 8'(PER_CYC - 1);
  localparam logic [7:0] ON_LIM   = 8'(ON_CYC);
  localparam logic [3:0] RUN_LAST = 4'(DONE_CYC);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(MAX_CYC - 1);

  logic en_s;
  logic vout_low_s;
  logic uvlo_n_s;

  pebble_sync2 #(.RST_VAL(1'b1)) u_sync_en (
    .clk(clk), .rst_n(rst_n), .d(en), .q(en_s)
  );
  pebble_sync2 #(.RST_VAL(1'b0)) u_sync_vl (
    .clk(clk), .rst_n(rst_n), .d(vout_low),
    .q(vout_low_s)
  );
  pebble_sync2 #(.RST_VAL(1'b0)) u_sync_uv (
    .clk(clk), .rst_n(rst_n), .d(uvlo_n),
    .q(uvlo_n_s)
  );

  dis_state_t       state_q, state_d;
  logic [7:0]       deg_q, deg_d;
  logic [7:0]       chop_q, chop_d;
  logic [CNT_W-1:0] to_q, to_d;
  logic [3:0]       run_q, run_d;
  logic fault_q, fault_d;
  logic arm_q, arm_d;
  logic pulse_q, pulse_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  always_comb begin
    state_d = state_q;
    deg_d   = deg_q;
    chop_d  = chop_q;
    to_d    = to_q;
    run_d   = run_q;
    fault_d = fault_q;
    if (fault_clr) fault_d = 1'b0;
    if (!uvlo_n_s) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!en_s) begin
            state_d = ST_DEGLITCH;
            deg_d   = 8'd1;
          end
        end
        ST_DEGLITCH: begin
          if (en_s) begin
            state_d = ST_IDLE;
          end else if (deg_q == DEG_LAST) begin
            state_d = ST_DISCHARGE;
            chop_d  = 8'd0;
            to_d    = '0;
            run_d   = 4'd0;
          end else begin
            deg_d = deg_q + 8'd1;
          end
        end
        ST_DISCHARGE: begin
          // Done is tested first so it wins a tie with timeout
          if (en_s) begin
            state_d = ST_IDLE;
          end else if (run_q == RUN_LAST) begin
            state_d = ST_DONE;
          end else if (to_q == TO_LAST) begin
            state_d = ST_TIMEOUT;
            fault_d = 1'b1;
          end else begin
            chop_d = (chop_q == PER_LAST) ?
                     8'd0 : chop_q + 8'd1;
            to_d   = to_q + CNT_W'(1);
            run_d  = vout_low_s ? run_q + 4'd1 : 4'd0;
          end
        end
        ST_DONE, ST_TIMEOUT: begin
          if (en_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    arm_d   = (state_d == ST_DISCHARGE);
    pulse_d = arm_d && (chop_d < ON_LIM);
    busy_d  = (state_d == ST_DEGLITCH) ||
              (state_d == ST_DISCHARGE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      deg_q   <= 8'd0;
      chop_q  <= 8'd0;
      to_q    <= '0;
      run_q   <= 4'd0;
      fault_q <= 1'b0;
      arm_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      deg_q   <= deg_d;
      chop_q  <= chop_d;
      to_q    <= to_d;
      run_q   <= run_d;
      fault_q <= fault_d;
      arm_q   <= arm_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dis_arm   = arm_q;
  assign dis_pulse = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;

endmodule
